// File: rtl/core_pkg.sv
// Shared execute-stage types: divider op selector and divider FSM states.
// Encoding of div_op_e is load-bearing: op[1] = remainder, op[0] = unsigned.
package core_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_e;

  function automatic logic div_is_rem(div_op_e op);
    return op[1];
  endfunction

  function automatic logic div_is_signed(div_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/core_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; XLEN+1 cycles to done, 1 for div-by-zero/overflow.
// Single request in flight: ready only in IDLE, start is ignored otherwise; kill abandons without a done pulse.
import core_pkg::*;

module core_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  div_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            isrem_q, isrem_d;
  logic            done_q, done_d;

  logic            sgn, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0] a_abs, b_abs, spec_res;
  logic [XLEN:0]   rem_sh, rem_nx;
  logic            ge;
  logic [XLEN-1:0] quo_nx, quo_fin, rem_fin;

  // Operand conditioning and early-out results on the accept cycle.
  always_comb begin
    sgn      = div_is_signed(op);
    a_neg    = sgn & a[XLEN-1];
    b_neg    = sgn & b[XLEN-1];
    a_abs    = a_neg ? -a : a;
    b_abs    = b_neg ? -b : b;
    b_zero   = (b == '0);
    ovf      = sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
    // Overflow quotient is the most negative value, which is exactly a.
    spec_res = b_zero ? (div_is_rem(op) ? a : '1)
                      : (div_is_rem(op) ? '0 : a);
  end

  // One restoring step; the stored partial remainder is always < divisor, so
  // only the shifted working value needs the extra bit.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[XLEN-1]};
    ge      = (rem_sh >= {1'b0, dvs_q});
    rem_nx  = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    quo_nx  = {dvd_q[XLEN-2:0], ge};
    quo_fin = negq_q ? -quo_nx : quo_nx;
    rem_fin = negr_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    res_d   = res_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    isrem_d = isrem_q;
    done_d  = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        if (start && !kill) begin
          isrem_d = div_is_rem(op);
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          dvd_d   = a_abs;
          dvs_d   = b_abs;
          rem_d   = '0;
          cnt_d   = '0;
          if (b_zero || ovf) begin
            res_d   = spec_res;
            done_d  = 1'b1;
            state_d = DIV_DONE;
          end else begin
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d = rem_nx[XLEN-1:0];
        dvd_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          res_d   = isrem_q ? rem_fin : quo_fin;
          done_d  = 1'b1;
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    if (kill) begin
      state_d = DIV_IDLE;
      done_d  = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      isrem_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      isrem_q <= isrem_d;
      done_q  <= done_d;
    end
  end

  assign ready  = (state_q == DIV_IDLE);
  assign done   = done_q;
  assign result = res_q;

endmodule

// File: tb/tb_core_div.sv
// Scoreboarded bench for core_div: directed vectors push expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_core_div;
  import core_pkg::*;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        kill  = 1'b0;
  div_op_e     op    = DIV_DIV;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        ready;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  core_div #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input string name, input div_op_e o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res, input int lat,
                       input bit push, output int acc);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready: ready still 0 after %0d cycles, required 1", name, n);
    end
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    acc   = cyc + 1;
    if (push) sb.push_back('{exp_res, acc + lat - 1, name});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done pulse seen, required result 0x%08h at cycle %0d",
               e.name, e.res, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no request pending (result 0x%08h), required done=0",
                 result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc, acc2;
    logic [31:0] last_res;

    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 32'd1);
    chk("reset_done", done, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal path, latency 33
    issue("div_100_7",   DIV_DIV,  32'd100,      32'd7,          32'd14,         33, 1, acc);
    issue("rem_100_7",   DIV_REM,  32'd100,      32'd7,          32'd2,          33, 1, acc);
    issue("rem_m7_2",    DIV_REM,  32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF,   33, 1, acc);
    issue("div_m7_2",    DIV_DIV,  32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   33, 1, acc);
    issue("divu_m7_2",   DIV_DIVU, 32'hFFFFFFF9, 32'd2,          32'h7FFFFFFC,   33, 1, acc);
    issue("div_7_m2",    DIV_DIV,  32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   33, 1, acc);
    issue("rem_7_m2",    DIV_REM,  32'd7,        32'hFFFFFFFE,   32'd1,          33, 1, acc);
    issue("divu_max_10", DIV_DIVU, 32'hFFFFFFFF, 32'd10,         32'h19999999,   33, 1, acc);
    issue("remu_max_10", DIV_REMU, 32'hFFFFFFFF, 32'd10,         32'd5,          33, 1, acc);
    issue("div_min_1",   DIV_DIV,  32'h80000000, 32'd1,          32'h80000000,   33, 1, acc);
    issue("divu_min_m1", DIV_DIVU, 32'h80000000, 32'hFFFFFFFF,   32'd0,          33, 1, acc);
    // Early-out path, latency 1
    issue("divu_5_0",    DIV_DIVU, 32'd5,        32'd0,          32'hFFFFFFFF,   1,  1, acc);
    issue("remu_5_0",    DIV_REMU, 32'd5,        32'd0,          32'd5,          1,  1, acc);
    issue("div_5_0",     DIV_DIV,  32'd5,        32'd0,          32'hFFFFFFFF,   1,  1, acc);
    issue("rem_m7_0",    DIV_REM,  32'hFFFFFFF9, 32'd0,          32'hFFFFFFF9,   1,  1, acc);
    issue("div_ovf",     DIV_DIV,  32'h80000000, 32'hFFFFFFFF,   32'h80000000,   1,  1, acc);
    issue("rem_ovf",     DIV_REM,  32'h80000000, 32'hFFFFFFFF,   32'd0,          1,  1, acc);
    drain();
    last_res = 32'd0;

    // Kill in cycle 10 of CALC
    issue("kill_op", DIV_DIV, 32'd1000, 32'd3, 32'd0, 33, 0, acc);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_ready", ready, 32'd1);
    chk("kill_done", done, 32'd0);
    chk("kill_result", result, last_res);
    op    = DIV_DIVU;
    a     = 32'd9;
    b     = 32'd3;
    start = 1'b1;
    kill  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    chk("kill_start_not_accepted", ready, 32'd1);
    repeat (40) @(negedge clk);
    chk("kill_result_hold", result, last_res);

    // Reset pulse in cycle 20 of CALC
    issue("rst_op", DIV_DIVU, 32'd1000, 32'd3, 32'd0, 33, 0, acc);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", ready, 32'd1);
    chk("rst_mid_done", done, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_no_stale_done", done, 32'd0);

    // Back-to-back pair
    issue("pair1", DIV_DIVU, 32'd1000, 32'd3, 32'd333, 33, 1, acc);
    issue("pair2", DIV_REMU, 32'd1000, 32'd3, 32'd1,   33, 1, acc2);
    chk("pair_accept_gap", acc2 - acc, 32'd34);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_div.md
# core_div

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the `EXEC_DIV` engine of the execute stage. It consumes operands and a `div_op_e` selector from the decoder/exec-source mux and returns one XLEN result to the writeback mux. Special cases (divide-by-zero, signed overflow) finish early; all other operations take a fixed number of cycles.

## Interface
- `XLEN`, default 32: operand and result width.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; accepted only when `ready`=1.
- `op`  in  `div_op_e` (2): DIV_DIV / DIV_DIVU / DIV_REM / DIV_REMU, sampled on accept.
- `a`  in  XLEN: dividend, sampled on accept.
- `b`  in  XLEN: divisor, sampled on accept.
- `kill`  in  1: flush (trap/redirect); abandons any operation in flight.
- `ready`  out  1: high in IDLE only.
- `done`  out  1: one-cycle pulse; `result` valid while high.
- `result`  out  XLEN: quotient or remainder; holds its last value when `done`=0.

## Operation
- States (`div_state_e`): IDLE, CALC, DONE.
- IDLE: `ready`=1. `start`=1 and `kill`=0 latches `op`, `a`, `b`.
  - If `b`==0 or (signed op and `a`==2^(XLEN-1) and `b`==all-ones), the result is computed directly and the state moves to DONE.
  - Otherwise the state moves to CALC with counter=0.
- Setup on accept: for signed ops (DIV, REM), operands are replaced by their absolute values. Record `neg_q` = sign(a) XOR sign(b) and `neg_r` = sign(a). Unsigned ops clear both flags.
- CALC, one restoring step per cycle:
  - rem = {rem[XLEN-1:0], dvd[XLEN-1]}; dvd <<= 1.
  - If rem >= {0,divisor}: rem -= divisor and the quotient LSB is 1, else 0.
  - rem is XLEN+1 bits wide.
  - The counter increments each step. After step XLEN (counter = XLEN-1 at the edge), the state moves to DONE and the result register loads:
    - quotient, negated if `neg_q`, for DIV/DIVU;
    - remainder, negated if `neg_r`, for REM/REMU.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- Special results:
  - Divide by zero: quotient = all-ones (both signednesses); remainder = `a`.
  - Overflow: DIV gives 2^(XLEN-1); REM gives 0.
- `kill`=1 in any state: next state is IDLE, `done` is suppressed, `result` is unchanged. `kill` together with `start` in IDLE means the request is not accepted.
- `start` while not `ready` is ignored; the caller stalls.

## Timing
- Reset values: state=IDLE, `ready`=1, `done`=0, `result`=0, counter=0, all datapath registers 0.
- Normal latency: request accepted at edge 0; CALC occupies cycles 1..XLEN; `done` is high in cycle XLEN+1 (cycle 33 for XLEN=32). Next accept is possible in cycle XLEN+2.
- Special-case latency: `done` is high in cycle 1, and `ready` returns in cycle 2.
- `done` and `result` are registered outputs with no combinational path from inputs.
- `ready` is decoded from the state register only.
- Reset asserted mid-operation: immediately IDLE, `done`=0, and no stale pulse after release.

## Structure
- Add to `core_pkg`: `div_state_e` {DIV_IDLE, DIV_CALC, DIV_DONE}. `div_op_e` is reused as-is.
- `op[1]` selects remainder; `op[0]` selects unsigned. The implementation relies on this encoding.
- Single module with no sub-modules. The counter width is $clog2(XLEN).

## Test plan
- DIV a=100, b=7 -> `done` in cycle 33, `result`=14; REM with the same operands -> 2.
- REM a=-7 (0xFFFFFFF9), b=2 -> `result`=0xFFFFFFFF. DIV with the same operands -> 0xFFFFFFFD (-3). DIVU with the same operands -> 0x7FFFFFFC.
- DIVU a=5, b=0 -> `done` in cycle 1, `result`=0xFFFFFFFF. REMU with the same operands -> 5, also with 1-cycle latency.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 in cycle 1; REM with the same operands -> 0.
- `kill` in cycle 10 of CALC -> no `done` pulse, `ready`=1 the next cycle, `result` unchanged. Then `start` during `kill` -> not accepted.
- `rst` pulsed in cycle 20 of CALC -> `ready`=1 and `done`=0 immediately. Then `start` a back-to-back pair -> the second request is accepted in the cycle after `done`.
